// File: rtl/relay_bank.sv
`default_nettype none
// ============================================================================
//  Module   : relay_bank
//  Purpose  : Bank of N independent changeover-relay models driven by a
//             shared tick strobe. Each channel has a normally-open and a
//             normally-closed contact, operate / release / alternate-release
//             timing, and a break-before-make transit gap in which both
//             contacts are open.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1  system clock
//    rst_n     in   1  asynchronous active-low reset
//    tick      in   1  timebase strobe (one clk wide); all timing counts ticks
//    e         in   N  coil energise per channel
//    ar        in   N  alternate-release select, sampled when release begins
//    c_no      out  N  normally-open contact closed
//    c_nc      out  N  normally-closed contact closed
//    busy      out  N  channel is in a timed or transit state
//    any_busy  out  1  OR of busy
// ----------------------------------------------------------------------------
//  Optional feature
//    RELAY_BOUNCE_EN : when defined, c_no bounces for T_BOUNCE ticks after
//                      pull-in. When undefined no bounce logic is built.
// ============================================================================
module relay_bank #(
  parameter int N        = 4,
  parameter int T_OP     = 10,
  parameter int T_REL    = 10,
  parameter int T_ALT    = 20,
  parameter int T_BBM    = 2,
  parameter int T_BOUNCE = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [N-1:0] e,
  input  logic [N-1:0] ar,
  output logic [N-1:0] c_no,
  output logic [N-1:0] c_nc,
  output logic [N-1:0] busy,
  output logic         any_busy
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_OP, T_REL), max2(T_ALT, T_BBM)), T_BOUNCE);
  localparam int W     = $clog2(T_MAX + 1);

  localparam logic [W-1:0] OP_LOAD  = W'(T_OP);
  localparam logic [W-1:0] REL_LOAD = W'(T_REL);
  localparam logic [W-1:0] ALT_LOAD = W'(T_ALT);
  localparam logic [W-1:0] BBM_LOAD = W'(T_BBM);
  localparam logic [W-1:0] ONE      = W'(1);
  localparam bit           HAS_BBM  = (T_BBM > 0);

  typedef enum logic [2:0] {
    ST_OPEN    = 3'd0,
    ST_PULLING = 3'd1,
    ST_BREAK   = 3'd2,
    ST_PULLED  = 3'd3,
    ST_OPENING = 3'd4,
    ST_RETURN  = 3'd5
  } state_t;

  for (genvar g = 0; g < N; g++) begin : g_ch
    state_t         state_q, state_d;
    logic [W-1:0]   ctr_q, ctr_d;
    logic           done;
    logic           enter_pulled;

    // The count ends on the tick that takes the counter from 1 to 0; the
    // entry edge reloads the counter, so a tick there is never counted.
    assign done = tick && (ctr_q == ONE);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_OPEN;
        ctr_q   <= '0;
      end else begin
        state_q <= state_d;
        ctr_q   <= ctr_d;
      end
    end

    always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      case (state_q)
        ST_OPEN: begin
          if (e[g]) begin
            state_d = ST_PULLING;
            ctr_d   = OP_LOAD;
          end
        end
        ST_PULLING: begin
          if (!e[g]) begin
            state_d = ST_OPEN;
            ctr_d   = '0;
          end else if (done) begin
            if (HAS_BBM) begin
              state_d = ST_BREAK;
              ctr_d   = BBM_LOAD;
            end else begin
              state_d = ST_PULLED;
              ctr_d   = '0;
            end
          end else if (tick) begin
            ctr_d = ctr_q - ONE;
          end
        end
        ST_BREAK: begin
          // Dropping the coil mid-transit swings the armature back through
          // a full transit gap rather than snapping to OPEN.
          if (!e[g]) begin
            state_d = ST_RETURN;
            ctr_d   = BBM_LOAD;
          end else if (done) begin
            state_d = ST_PULLED;
            ctr_d   = '0;
          end else if (tick) begin
            ctr_d = ctr_q - ONE;
          end
        end
        ST_PULLED: begin
          if (!e[g]) begin
            state_d = ST_OPENING;
            ctr_d   = ar[g] ? ALT_LOAD : REL_LOAD;
          end
        end
        ST_OPENING: begin
          if (e[g]) begin
            state_d = ST_PULLED;
            ctr_d   = '0;
          end else if (done) begin
            if (HAS_BBM) begin
              state_d = ST_RETURN;
              ctr_d   = BBM_LOAD;
            end else begin
              state_d = ST_OPEN;
              ctr_d   = '0;
            end
          end else if (tick) begin
            ctr_d = ctr_q - ONE;
          end
        end
        ST_RETURN: begin
          if (e[g]) begin
            state_d = ST_BREAK;
            ctr_d   = BBM_LOAD;
          end else if (done) begin
            state_d = ST_OPEN;
            ctr_d   = '0;
          end else if (tick) begin
            ctr_d = ctr_q - ONE;
          end
        end
        default: begin
          state_d = ST_OPEN;
          ctr_d   = '0;
        end
      endcase
    end

    // Pull-in completes from either the operate count (no transit gap) or
    // the make side of the transit gap.
    assign enter_pulled = ((state_q == ST_PULLING) || (state_q == ST_BREAK)) &&
                          (state_d == ST_PULLED);

`ifdef RELAY_BOUNCE_EN
    localparam logic [W-1:0] BOUNCE_LOAD = W'(T_BOUNCE);

    logic [W-1:0] bctr_q, bctr_d;
    logic         bbit_q, bbit_d;
    logic         bouncing;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bctr_q <= '0;
        bbit_q <= 1'b0;
      end else begin
        bctr_q <= bctr_d;
        bbit_q <= bbit_d;
      end
    end

    always_comb begin
      bctr_d = bctr_q;
      bbit_d = bbit_q;
      if (enter_pulled) begin
        bctr_d = BOUNCE_LOAD;
        bbit_d = 1'b1;
      end else if ((state_q == ST_PULLED) && (state_d == ST_PULLED)) begin
        if (tick && (bctr_q != '0)) begin
          bctr_d = bctr_q - ONE;
          bbit_d = ~bbit_q;
        end
      end else begin
        // Leaving PULLED (or never in it) abandons any bounce in progress.
        bctr_d = '0;
        bbit_d = 1'b0;
      end
    end

    assign bouncing = (state_q == ST_PULLED) && (bctr_q != '0);

    assign c_no[g] = bouncing ? bbit_q
                              : ((state_q == ST_PULLED) || (state_q == ST_OPENING));
    assign busy[g] = bouncing ||
                     !((state_q == ST_OPEN) || (state_q == ST_PULLED));
`else
    logic unused_enter;
    assign unused_enter = enter_pulled;

    assign c_no[g] = (state_q == ST_PULLED) || (state_q == ST_OPENING);
    assign busy[g] = !((state_q == ST_OPEN) || (state_q == ST_PULLED));
`endif

    assign c_nc[g] = (state_q == ST_OPEN) || (state_q == ST_PULLING);
  end : g_ch

  assign any_busy = |busy;

endmodule : relay_bank
`default_nettype wire
